// File: rtl/hazard_unit.sv
// Hazard detection and forwarding for the 5-stage ARM pipeline: load-use stall,
// branch/PC-write flushes, ALU operand bypass selects and saturating stall/flush counters.
module hazard_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       RA1D,
    input  logic [3:0]       RA2D,
    input  logic [3:0]       WA3D,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             BranchTakenE,
    input  logic             PCSrcD,
    input  logic             PCSrcE,
    input  logic             PCSrcM,
    input  logic             PCSrcW,
    input  logic             CntClr,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam logic [3:0]       PC_REG  = 4'd15;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [3:0]       ra1e_q, ra1e_d;
    logic [3:0]       ra2e_q, ra2e_d;
    logic [3:0]       wa3e_q, wa3e_d;
    logic [3:0]       wa3m_q, wa3m_d;
    logic [3:0]       wa3w_q, wa3w_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             ldr_stall;
    logic             pc_wr_pending;

    // Newest producer (M) wins over W; R15 reads the PC and is never bypassed.
    function automatic logic [1:0] fwd_sel(
        input logic [3:0] ra,
        input logic [3:0] wa_m,
        input logic       wr_m,
        input logic [3:0] wa_w,
        input logic       wr_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (ra != PC_REG) begin
            if (wr_m && (ra == wa_m))      sel = 2'b10;
            else if (wr_w && (ra == wa_w)) sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        ldr_stall     = MemtoRegE && ((RA1D == wa3e_q) || (RA2D == wa3e_q));
        pc_wr_pending = PCSrcD | PCSrcE | PCSrcM;
        StallD        = ldr_stall;
        StallF        = ldr_stall | pc_wr_pending;
        FlushE        = ldr_stall | BranchTakenE;
        FlushD        = pc_wr_pending | PCSrcW | BranchTakenE;
        ForwardAE     = fwd_sel(ra1e_q, wa3m_q, RegWriteM, wa3w_q, RegWriteW);
        ForwardBE     = fwd_sel(ra2e_q, wa3m_q, RegWriteM, wa3w_q, RegWriteW);
        StallCnt      = stall_cnt_q;
        FlushCnt      = flush_cnt_q;
    end

    // The flushed bubble carries WA3E=0 with MemtoRegE low, so a load-use stall lasts one cycle.
    always_comb begin
        ra1e_d = FlushE ? 4'd0 : RA1D;
        ra2e_d = FlushE ? 4'd0 : RA2D;
        wa3e_d = FlushE ? 4'd0 : WA3D;
        wa3m_d = wa3e_q;
        wa3w_d = wa3m_q;

        stall_cnt_d = stall_cnt_q;
        if (CntClr)
            stall_cnt_d = '0;
        else if (StallD && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_ONE;

        flush_cnt_d = flush_cnt_q;
        if (CntClr)
            flush_cnt_d = '0;
        else if (FlushE && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ra1e_q      <= '0;
            ra2e_q      <= '0;
            wa3e_q      <= '0;
            wa3m_q      <= '0;
            wa3w_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ra1e_q      <= ra1e_d;
            ra2e_q      <= ra2e_d;
            wa3e_q      <= wa3e_d;
            wa3m_q      <= wa3m_d;
            wa3w_q      <= wa3w_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed vectors with literal expectations plus a
// per-cycle comparison against a stage-queue model of the pipeline.
module tb_hazard_unit;

    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic [3:0]       RA1D, RA2D, WA3D;
    logic             RegWriteM, RegWriteW, MemtoRegE, BranchTakenE;
    logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW, CntClr;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, FlushD, FlushE;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    hazard_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .CntClr(CntClr),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: source regs of the instruction in E, and the destination held by each of E, M, W.
    int m_ra1 = 0, m_ra2 = 0;
    int m_dst [3] = '{0, 0, 0};
    int m_scnt = 0, m_fcnt = 0;

    function automatic int m_fwd(input int ra);
        if (ra == 15) return 0;
        if (RegWriteM && ra == m_dst[1]) return 2;
        if (RegWriteW && ra == m_dst[2]) return 1;
        return 0;
    endfunction

    function automatic bit m_ldr();
        return MemtoRegE && (int'(RA1D) == m_dst[0] || int'(RA2D) == m_dst[0]);
    endfunction

    function automatic bit m_flushe();
        return m_ldr() || BranchTakenE;
    endfunction

    function automatic bit m_pcpend();
        return PCSrcD || PCSrcE || PCSrcM;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ra1 <= 0; m_ra2 <= 0;
            m_dst[0] <= 0; m_dst[1] <= 0; m_dst[2] <= 0;
            m_scnt <= 0; m_fcnt <= 0;
        end else begin
            m_ra1    <= m_flushe() ? 0 : int'(RA1D);
            m_ra2    <= m_flushe() ? 0 : int'(RA2D);
            m_dst[0] <= m_flushe() ? 0 : int'(WA3D);
            m_dst[1] <= m_dst[0];
            m_dst[2] <= m_dst[1];
            m_scnt   <= CntClr ? 0 : (m_ldr() ? ((m_scnt + 1 > CMAX) ? CMAX : m_scnt + 1) : m_scnt);
            m_fcnt   <= CntClr ? 0 : (m_flushe() ? ((m_fcnt + 1 > CMAX) ? CMAX : m_fcnt + 1) : m_fcnt);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cmp_ForwardAE", int'(ForwardAE), m_fwd(m_ra1));
            chk("cmp_ForwardBE", int'(ForwardBE), m_fwd(m_ra2));
            chk("cmp_StallD",    int'(StallD),    int'(m_ldr()));
            chk("cmp_StallF",    int'(StallF),    int'(m_ldr() || m_pcpend()));
            chk("cmp_FlushE",    int'(FlushE),    int'(m_flushe()));
            chk("cmp_FlushD",    int'(FlushD),    int'(m_pcpend() || PCSrcW || BranchTakenE));
            chk("cmp_StallCnt",  int'(StallCnt),  m_scnt);
            chk("cmp_FlushCnt",  int'(FlushCnt),  m_fcnt);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 0;
        RA1D = 0; RA2D = 0; WA3D = 0;
        RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; BranchTakenE = 0;
        PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0; CntClr = 0;
        @(posedge clk);
        started = 1;
        @(posedge clk); #1;
        chk("rst_StallCnt", int'(StallCnt), 0);
        chk("rst_FlushCnt", int'(FlushCnt), 0);
        chk("rst_FwdA_idle", int'(ForwardAE), 0);
        // Cleared RA1E and WA3M are both R0, so a live RegWriteM forwards from M.
        RegWriteM = 1; #1;
        chk("rst_FwdA_rwm", int'(ForwardAE), 2);
        RegWriteM = 0;

        // ADD R1 enters decode, then consumer of R1
        reset = 1; WA3D = 1; nxt();
        RA1D = 1; WA3D = 0; nxt();
        RegWriteM = 1; #1;
        chk("t1_FwdA_M", int'(ForwardAE), 2);
        chk("t1_FwdB_M", int'(ForwardBE), 0);
        nxt();
        RegWriteM = 0; RegWriteW = 1; RA1D = 0; WA3D = 2; #1;
        chk("t1_FwdA_W", int'(ForwardAE), 1);
        nxt();

        // R2 written by two in-flight instructions; M must win
        RegWriteW = 0; WA3D = 2; nxt();
        RA1D = 15; RA2D = 2; WA3D = 15; nxt();
        RegWriteM = 1; RegWriteW = 1; #1;
        chk("t2_FwdB_double", int'(ForwardBE), 2);
        chk("t2_FwdA_r15", int'(ForwardAE), 0);
        RA1D = 15; RA2D = 0; WA3D = 0; nxt();
        RegWriteW = 0; #1;
        chk("t2_FwdA_r15_M", int'(ForwardAE), 0);
        RA1D = 0; WA3D = 3; nxt();

        // LDR R3 in E, consumer reads R3 as operand B
        RegWriteM = 0; MemtoRegE = 1; RA2D = 3; WA3D = 0; #1;
        chk("t3_StallF", int'(StallF), 1);
        chk("t3_StallD", int'(StallD), 1);
        chk("t3_FlushE", int'(FlushE), 1);
        chk("t3_FlushD", int'(FlushD), 0);
        nxt();
        MemtoRegE = 0; #1;
        chk("t3_StallD_drop", int'(StallD), 0);
        chk("t3_FlushE_drop", int'(FlushE), 0);
        chk("t3_StallCnt", int'(StallCnt), 1);
        nxt();
        // Consumer now in E while the load has moved on to W
        RegWriteW = 1; CntClr = 1; RA2D = 0; WA3D = 5; #1;
        chk("t3_FwdB_load", int'(ForwardBE), 1);
        nxt();

        // Load-use stall coinciding with a taken branch
        CntClr = 0; RegWriteW = 0; MemtoRegE = 1; RA1D = 5; BranchTakenE = 1; #1;
        chk("t4_FlushE", int'(FlushE), 1);
        chk("t4_FlushD", int'(FlushD), 1);
        chk("t4_StallD", int'(StallD), 1);
        nxt();
        MemtoRegE = 0; RA1D = 0; BranchTakenE = 0; WA3D = 0; #1;
        chk("t4_FlushCnt", int'(FlushCnt), 1);
        chk("t4_StallCnt", int'(StallCnt), 1);
        nxt();

        // PC write walking D, E, M, W
        for (int i = 0; i < 4; i++) begin
            PCSrcD = (i == 0); PCSrcE = (i == 1); PCSrcM = (i == 2); PCSrcW = (i == 3); #1;
            chk("t5_StallF", int'(StallF), (i < 3) ? 1 : 0);
            chk("t5_FlushD", int'(FlushD), 1);
            nxt();
        end
        PCSrcW = 0;

        // Counter saturation, clear-over-increment, then async reset mid-run
        BranchTakenE = 1;
        repeat (20) nxt();
        chk("t6_FlushCnt_sat", int'(FlushCnt), 15);
        CntClr = 1; nxt();
        CntClr = 0; #1;
        chk("t6_FlushCnt_clr", int'(FlushCnt), 0);
        repeat (3) nxt();
        BranchTakenE = 0; RA1D = 4; WA3D = 6; #1;
        chk("t6_FlushCnt_3", int'(FlushCnt), 3);
        nxt();
        RA1D = 4; WA3D = 9; nxt();
        RegWriteM = 1; MemtoRegE = 1; RA1D = 0; #1;
        chk("t6_pre_FwdA", int'(ForwardAE), 0);
        chk("t6_pre_StallD", int'(StallD), 0);
        reset = 0; #1;
        chk("t6_rst_FlushCnt", int'(FlushCnt), 0);
        chk("t6_rst_StallCnt", int'(StallCnt), 0);
        chk("t6_rst_FwdA", int'(ForwardAE), 2);
        chk("t6_rst_StallD", int'(StallD), 1);
        nxt();
        reset = 1; RegWriteM = 0; MemtoRegE = 0;
        repeat (3) nxt();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
